// File: rtl/ad9228_capture_buffer.sv
// ad9228_capture_buffer
// Pre/post-trigger capture window for one AD9228 channel. It writes valid gearbox samples into a
// circular RAM. After a trigger it stops once the window is complete. It then streams the DEPTH
// stored words oldest-first over a valid/ready interface.
// Optional feature: define AD9228_CAPTURE_TSTAMP_EN to add the trig_timestamp output, which
// reports the valid-sample count at the trigger.
module ad9228_capture_buffer #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 1024,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  dco_div4,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     pre_samples,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  armed
`ifdef AD9228_CAPTURE_TSTAMP_EN
    ,
    output logic [31:0]           trig_timestamp
`endif
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_READOUT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]     pre_q, pre_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CNT_W-1:0]      pre_cnt;
    logic [CNT_W-1:0]      post_len;
    logic                  fill_done;
    logic                  post_done;
    logic                  xfer;
    logic                  load;

    // Shared conditions; cnt_q counts fill, post and issued-readout words depending on state
    always_comb begin
        pre_cnt   = {1'b0, pre_q};
        post_len  = DEPTH_CNT - pre_cnt;
        fill_done = (pre_q == '0) || (data_valid_in && (cnt_q + 1'b1 == pre_cnt));
        post_done = (cnt_q == post_len);
        xfer      = m_valid_q && m_ready;
        load      = (!m_valid_q || m_ready) && (cnt_q != DEPTH_CNT);
    end

    // State register
    always_ff @(posedge dco_div4 or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything else
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (arm)              state_d = S_FILL;
                S_FILL:    if (fill_done)        state_d = S_ARMED;
                S_ARMED:   if (trigger)          state_d = S_POST;
                S_POST:    if (post_done)        state_d = S_READOUT;
                S_READOUT: if (xfer && m_last_q) state_d = S_IDLE;
                default:                         state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: sample writes, counters and the readout output register (the RAM read stage)
    always_comb begin
        wr_en     = 1'b0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pre_d     = pre_q;
        cnt_d     = cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        if (abort) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            cnt_d     = '0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        pre_d = pre_samples;
                        cnt_d = '0;
                    end
                end
                S_FILL: begin
                    if ((pre_q != '0) && data_valid_in) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        cnt_d    = fill_done ? '0 : cnt_q + 1'b1;
                    end
                end
                S_ARMED: begin
                    if (data_valid_in) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (trigger) begin
                        cnt_d = CNT_W'(data_valid_in);
                    end
                end
                S_POST: begin
                    if (post_done) begin
                        rd_ptr_d = wr_ptr_q;
                        cnt_d    = '0;
                    end else if (data_valid_in) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                    end
                end
                S_READOUT: begin
                    if (load) begin
                        m_data_d  = mem[rd_ptr_q];
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        m_valid_d = 1'b1;
                        m_last_d  = (cnt_q == LAST_CNT);
                    end else if (xfer) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge dco_div4 or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pre_q     <= '0;
            cnt_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    // Sample RAM write port (no reset so it maps onto block RAM)
    always_ff @(posedge dco_div4) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef AD9228_CAPTURE_TSTAMP_EN
    logic [31:0] ts_cnt_q, ts_cnt_d;
    logic [31:0] ts_q, ts_d;

    // Free-running valid-sample counter; its value is captured on the cycle the trigger is accepted
    always_comb begin
        ts_cnt_d = data_valid_in ? ts_cnt_q + 32'd1 : ts_cnt_q;
        ts_d     = (state_q == S_ARMED && trigger && !abort) ? ts_cnt_q : ts_q;
    end

    // Timestamp registers
    always_ff @(posedge dco_div4 or negedge rstn) begin
        if (!rstn) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            ts_q     <= ts_d;
        end
    end
`endif

    // Output decode
    always_comb begin
        m_data  = m_data_q;
        m_valid = m_valid_q;
        m_last  = m_last_q;
        busy    = (state_q != S_IDLE);
        armed   = (state_q == S_ARMED);
`ifdef AD9228_CAPTURE_TSTAMP_EN
        trig_timestamp = ts_q;
`endif
    end

endmodule
